// File: rtl/rr_code_pkg.sv
// Shared definitions for the round-robin code arbiter: sizes, FSM state
// encoding and the rotate helper used by the pick logic.
package rr_code_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    // IDLE: nothing offered downstream. OFFER: code holds a live grant.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // Rotate a request vector right so that bit 'sh' lands on bit 0.
    // Doubling the vector makes the wrap-around a plain shift.
    function automatic logic [N_REQ-1:0] rotate_right(
        input logic [N_REQ-1:0] vec,
        input logic [IDX_W-1:0] sh
    );
        logic [2*N_REQ-1:0] dbl;
        dbl = {vec, vec} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage : rr_code_pkg

// File: rtl/rr_code_arbiter_chk.sv
// Protocol checker for the arbiter outputs: a stalled grant must stay put,
// and each handshake must advance the transfer counter by exactly one.
module rr_code_arbiter_chk
    import rr_code_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    input logic             valid,
    input logic             ready,
    input logic [IDX_W-1:0] code,
    input logic [CNT_W-1:0] xfer_cnt
);

    a_grant_held: assert property (
        @(posedge clk) disable iff (!rst_n)
        (valid && !ready) |=> (valid && $stable(code))
    );

    a_cnt_step: assert property (
        @(posedge clk) disable iff (!rst_n)
        (valid && ready) |=> (xfer_cnt == CNT_W'($past(xfer_cnt) + 8'd1))
    );

    a_cnt_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(valid && ready) |=> $stable(xfer_cnt)
    );

endmodule : rr_code_arbiter_chk

// File: rtl/rr_code_arbiter_pick.sv
// Combinational round-robin pick: finds the first set request at or above
// 'start', wrapping from 7 back to 0. Rotate so 'start' becomes bit 0,
// take the lowest set bit, then add 'start' back to undo the rotation.
module rr_pick
    import rr_code_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] enc_s;

    // Rotate the requests so the search origin sits at bit 0.
    always_comb begin
        rot_s = rotate_right(req, start);
    end

    // Lowest set bit of the rotated vector; walking downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        enc_s = {IDX_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                enc_s = IDX_W'(k);
            end else begin
                enc_s = enc_s;
            end
        end
    end

    // Undo the rotation (modulo-8 add) and flag whether anything was found.
    always_comb begin
        idx = enc_s + start;
        any = |req;
    end

endmodule : rr_pick

// File: rtl/rr_code_arbiter.sv
// Round-robin arbiter over eight level-sensitive requests. The winner is
// presented as a registered 3-bit code with valid/ready; the grant is held
// until accepted and the next pick starts just above the last accepted code.
module rr_code_arbiter
    import rr_code_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] code,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Cleared by reset, set by the first edge afterwards, so requests are
    // only acted on from the second edge following reset release.
    logic             armed_q, armed_d;

    logic             hs_s;
    logic [IDX_W-1:0] pick_start_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;

    // Handshake and search origin: during a handshake the pointer is about
    // to become the current code, so search from just above it already.
    always_comb begin
        hs_s = (state_q == OFFER) && ready;
        if (hs_s) begin
            pick_start_s = code_q + 3'd1;
        end else begin
            pick_start_s = ptr_q + 3'd1;
        end
    end

    rr_pick u_pick (
        .req   (req),
        .start (pick_start_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Next-state and register-input logic for the IDLE/OFFER machine.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (armed_q && pick_any_s) begin
                    code_d  = pick_idx_s;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end else begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    ptr_d = code_q;
                    cnt_d = cnt_q + 8'd1;
                    if (pick_any_s) begin
                        code_d  = pick_idx_s;
                        valid_d = 1'b1;
                        state_d = OFFER;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, grant and counter registers; reset discards any
    // pending grant without counting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        code     = code_q;
        valid    = valid_q;
        xfer_cnt = cnt_q;
    end

    rr_code_arbiter_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid_q),
        .ready    (ready),
        .code     (code_q),
        .xfer_cnt (cnt_q)
    );

endmodule : rr_code_arbiter

// File: tb/tb_rr_code_arbiter.sv
// Self-checking bench for rr_code_arbiter: directed scenarios plus random
// requests/ready, compared against a behavioural round-robin model.
module tb_rr_code_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic [7:0] xfer_cnt;

    int n_checks;
    int n_pass;

    // Behavioural model state
    int m_ptr;
    int m_code;
    bit m_valid;
    int m_cnt;
    bit m_armed;

    rr_code_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First requester strictly after 'last', wrapping; -1 if none.
    function automatic int model_pick(input int last, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 7;
        m_code  = 0;
        m_valid = 0;
        m_cnt   = 0;
        m_armed = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic rd);
        int p;
        if (m_valid) begin
            if (rd) begin
                m_ptr = m_code;
                m_cnt = (m_cnt + 1) % 256;
                p = model_pick(m_ptr, r);
                if (p >= 0) m_code = p;
                else        m_valid = 0;
            end
        end else if (m_armed && r != 8'h00) begin
            m_code  = model_pick(m_ptr, r);
            m_valid = 1;
        end
        m_armed = 1;
    endtask

    task automatic compare_model();
        check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
        check_eq("code", {29'd0, code}, m_code);
        check_eq("xfer_cnt", {24'd0, xfer_cnt}, m_cnt);
    endtask

    task automatic step(input logic [7:0] r, input logic rd);
        req   = r;
        ready = rd;
        @(posedge clk);
        model_edge(r, rd);
        @(negedge clk);
        compare_model();
    endtask

    // Assert reset asynchronously away from any edge, verify outputs drop
    // at once, then release on a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_code", {29'd0, code}, 32'd0);
        check_eq("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        ready    = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b1);
            check_eq("idle_valid", {31'd0, valid}, 32'd0);
        end

        // All requesting, ready held: codes rotate 0..7,0
        apply_reset();
        step(8'hFF, 1'b1);                      // arming edge after release
        check_eq("arm_valid", {31'd0, valid}, 32'd0);
        step(8'hFF, 1'b1);                      // first grant
        check_eq("ff_code0", {29'd0, code}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] dec;
            logic [7:0] one;
            step(8'hFF, 1'b1);
            one = 8'd1;
            dec = one << code;
            check_eq("ff_code", {29'd0, code}, k % 8);
            check_eq("ff_valid", {31'd0, valid}, 32'd1);
            check_eq("ff_dec", {24'd0, dec}, {24'd0, one << (k % 8)});
        end
        check_eq("ff_cnt8", {24'd0, xfer_cnt}, 32'd8);

        // Stall holds code 2, then one handshake with requests gone
        apply_reset();
        step(8'b0010_0100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'b0010_0100, 1'b0);
            check_eq("stall_code", {29'd0, code}, 32'd2);
        end
        step(8'h00, 1'b1);
        check_eq("drop_valid", {31'd0, valid}, 32'd0);
        check_eq("drop_cnt", {24'd0, xfer_cnt}, 32'd1);

        // Sole requester 5: re-granted every cycle, counter wraps at 256
        apply_reset();
        step(8'h20, 1'b1);
        step(8'h20, 1'b1);
        for (int i = 0; i < 256; i++) begin
            step(8'h20, 1'b1);
            check_eq("solo_code", {29'd0, code}, 32'd5);
        end
        check_eq("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 8'h00;
                1:       r = 8'd1 << $urandom_range(0, 7);
                default: r = 8'($urandom);
            endcase
            step(r, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an offer of code 6
        step(8'h40, 1'b1);
        step(8'h40, 1'b0);
        step(8'h40, 1'b0);
        check_eq("pre_rst_code", {29'd0, code}, 32'd6);
        check_eq("pre_rst_valid", {31'd0, valid}, 32'd1);
        req = 8'hFF;
        apply_reset();
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b0);
        check_eq("post_rst_code", {29'd0, code}, 32'd0);
        check_eq("post_rst_valid", {31'd0, valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rr_code_arbiter

// File: doc/rr_code_arbiter.md
# rr_code_arbiter

Round-robin arbiter that selects one of eight level-sensitive request lines and presents the winner as a 3-bit binary code with a valid/ready handshake. It sits directly upstream of the 3-to-8 decoder stage: `code[2:0]` drives the decoder inputs `i2..i0`, and the decoder turns the code back into a one-hot grant. It provides fair, stable, back-to-back selection.

## Interface
- `N_REQ`, 8: number of request lines. Fixed at 8 to match the decoder.
- `IDX_W`, 3: code width, log2(`N_REQ`).
- `CNT_W`, 8: width of the transfer counter.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  8  request lines, bit k = requester k, level-sensitive.
- `code`  out  3  granted index; bit 2 feeds decoder `i2`, bit 0 feeds `i0`.
- `valid`  out  1  `code` holds a grant.
- `ready`  in  1  downstream accepts the grant.
- `xfer_cnt`  out  8  count of completed handshakes, wraps modulo 256.

## Operation
- Reset values while `rst_n`=0:
  - `code`=3'd0, `valid`=0, `xfer_cnt`=0.
  - Internal last-grant pointer `ptr`=3'd7, so the first search starts at index 0.
  - State = IDLE.
- Pick function: search `req` starting at (`ptr`+1) mod 8 and proceed upward with wrap-around. The first set bit wins. `ptr` itself is checked last.
- States: IDLE, OFFER.
- IDLE:
  - `valid`=0.
  - If `req` != 0: register the pick into `code`, set `valid`=1, go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - `valid`=1. `code` is held stable until the handshake completes; a grant is never retracted.
  - If `req[code]` drops before the handshake, the grant is still held.
  - On `valid`&&`ready`:
    - `ptr`<=`code` and `xfer_cnt`<=`xfer_cnt`+1, wrapping 255 to 0.
    - The pick is re-evaluated with the updated `ptr`, using `req` as sampled in the handshake cycle.
    - If that pick finds any request: load `code`, keep `valid`=1, stay in OFFER (back-to-back).
    - Otherwise: `valid`<=0, go to IDLE.
- A sole persistent requester is re-granted on every handshake.
- `ready` is ignored while `valid`=0.
- Reset asserted mid-OFFER: outputs drop to reset values immediately and asynchronously, and the pending grant is discarded without being counted.

## Timing
- Latency: `req` seen nonzero at IDLE edge N gives `valid`=1 with `code` valid after edge N. The first clock edge with `ready`=1 completes the handshake.
- Throughput: one grant per cycle when `ready` is held high and requests are pending.
- No combinational path from `req` or `ready` to `code`/`valid`; all outputs are registered.
- `xfer_cnt` updates at the same edge as the handshake.
- Reset release: the first possible `valid` is after the second rising edge following deassertion (one edge synchronously samples `req` into IDLE).

## Structure
- Shared package `rr_code_pkg`:
  - Localparams `N_REQ`, `IDX_W`, `CNT_W`.
  - State enum `{IDLE, OFFER}`.
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: `req[7:0]`, `start[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Implemented as rotate, priority-encode, un-rotate.
- The top level holds the FSM, `ptr`, `code`/`valid` registers and counter.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles -> `valid`=0, `code`=0, `xfer_cnt`=0 throughout.
- `req`=8'hFF, `ready`=1 held -> `code` sequence 0,1,2,…,7,0; `valid` stays 1; `xfer_cnt`=8 after 8 handshakes. Each code, fed through the decoder, yields exactly one output high.
- `req`=8'b0010_0100, `ready`=0 for 3 cycles, then `req` drops to 8'h00 with `ready`=1 -> `code`=2 held stable while stalled; one handshake; then `valid`=0.
- Only `req[5]` held, `ready`=1 -> `code`=5 on every cycle, `xfer_cnt` increments each cycle. Wrap check: after 256 handshakes `xfer_cnt`=0.
- Assert `rst_n`=0 mid-OFFER with `code`=6 -> `valid`, `code`, `xfer_cnt` go to 0 before the next edge. After release with `req`=8'hFF, the first grant is `code`=0.
